// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small transmit FIFO; queued words are serialised
// back-to-back with a configurable data/parity/stop frame format.
module uart_tx_fifo #(
  parameter int CLK_DIV    = 217,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          data,
  input  logic                          send,
  output logic                          ready,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          uart_tx,
  output logic [2:0]                    state_dbg
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] TMAX = TW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BMAX = BW'(DATA_BITS - 1);
  localparam logic          SMAX = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_BITS-1:0]  mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr, rd_ptr;
  logic                  full, empty, push, pop;
  logic [DATA_BITS-1:0]  head;
  logic                  head_par;
  logic [TW-1:0]         timer_q, timer_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic                  stop_q, stop_d;
  logic [DATA_BITS-1:0]  shreg_q, shreg_d;
  logic                  par_q, par_d;
  logic                  tx_q, tx_d;
  logic                  bit_done;

  // Handshake: a word is taken on any rising edge where send && ready;
  // a send while ready is low is silently dropped.
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty      = (wr_ptr == rd_ptr);
  assign ready      = !full;
  assign push       = send && !full;
  assign fifo_count = wr_ptr - rd_ptr;
  assign head       = mem[rd_ptr[AW-1:0]];
  assign head_par   = (^head) ^ (PARITY == 1);

  assign bit_done   = (timer_q == TMAX);
  assign busy       = (state_q != IDLE);
  assign uart_tx    = tx_q;
  assign state_dbg  = state_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= data;
  end

  always_comb begin
    state_d = state_q;
    timer_d = (state_q == IDLE || bit_done) ? '0 : timer_q + 1'b1;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shreg_d = head;
          par_d   = head_par;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = shreg_q[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_q == BMAX) begin
            stop_d = 1'b0;
            if (PARITY != 0) begin
              state_d = PAR;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            shreg_d = {1'b0, shreg_q[DATA_BITS-1:1]};
            tx_d    = shreg_q[1];
          end
        end
      end
      PAR: begin
        if (bit_done) begin
          state_d = STOP;
          stop_d  = 1'b0;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (bit_done) begin
          if (stop_q == SMAX) begin
            // Chain straight into the next frame when a word is waiting.
            if (!empty) begin
              pop     = 1'b1;
              shreg_d = head;
              par_d   = head_par;
              state_d = START;
              tx_d    = 1'b0;
            end else begin
              state_d = IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            stop_d = 1'b1;
            tx_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      timer_q <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with a configurable frame format (data bits, parity, stop bits) and an internal transmit FIFO. The FIFO lets producers such as the LED-array command and status path push several bytes back-to-back without waiting per frame. Queued frames are serialised on `uart_tx` with no idle gap between them. Baud rate is fixed at elaboration as clocks per bit.

## Interface
- `CLK_DIV`, 217, clock cycles per serial bit; must be ≥ 2.
- `DATA_BITS`, 8, data bits per frame; legal range 5..9.
- `PARITY`, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1, stop bits per frame; legal values 1 or 2.
- `FIFO_DEPTH`, 4, FIFO entries; must be a power of 2, ≥ 2.

- `clk`  in  1  clock
- `rst`  in  1  reset: synchronous, active-low.
- `data`  in  DATA_BITS  word to queue.
- `send`  in  1  push request; accepted only when `send && ready` at a rising edge.
- `ready`  out  1  FIFO not full.
- `busy`  out  1  serialiser mid-frame.
- `fifo_count`  out  clog2(FIFO_DEPTH)+1  number of queued words.
- `uart_tx`  out  1  serial line, registered, idle high.

## Operation
- **FIFO**
  - Circular buffer with read/write pointers one bit wider than the index.
  - full = MSBs of the pointers differ and the index bits are equal.
  - `ready` = !full.
  - A `send` while full is dropped. Nothing is stored and no error is flagged.
- **Frame**, transmitted in this order:
  - start bit (0)
  - data bits, LSB first
  - parity bit, if `PARITY` ≠ 0
  - `STOP_BITS` stop bits (1)
- **Parity**: even = XOR of the data bits; odd = inverted XOR. Computed from the popped word.
- **Frame length** = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLK_DIV cycles.
- **Serialiser states**: IDLE, START, DATA, PAR, STOP.
  - IDLE → START: FIFO non-empty. The word is popped into the shift register on the same edge.
  - START → DATA: bit timer done.
  - DATA → DATA: bit timer done; shifts and increments the bit index. Runs for DATA_BITS bits.
  - DATA → PAR (if `PARITY` ≠ 0) or STOP (otherwise): last data bit done.
  - PAR → STOP: bit timer done.
  - STOP → STOP: bit timer done on a stop bit that is not the last.
  - STOP → START or IDLE, after the last stop bit's timer is done:
    - FIFO non-empty → START, popping the next word on the same edge (zero-gap chaining).
    - FIFO empty → IDLE.
- **Bit timer**: counter of width clog2(CLK_DIV), 0..CLK_DIV−1. It clears on each bit boundary and is held at 0 in IDLE. Bit done = counter == CLK_DIV−1.
- **`uart_tx` register**: loaded on each state or bit transition with the value of the bit about to be sent. Forced to 1 in IDLE.
- **`busy`**: high in every state except IDLE.
- **Push and pop in the same cycle** (pop happens in IDLE→START and STOP→START): both take effect and `fifo_count` is unchanged. When full, the push is still refused because `ready` is low.

## Timing
- **Reset** (`rst` low at an edge), effective at that edge:
  - `uart_tx` = 1, `busy` = 0, `ready` = 1, `fifo_count` = 0.
  - State = IDLE, pointers = 0, bit timer = 0.
- **Reset mid-frame**: the frame is aborted, the line returns high on the next edge, and FIFO contents are discarded.
- **Push latency**: `send` accepted at edge E with the serialiser in IDLE and the FIFO empty gives:
  - `fifo_count` = 1 after E;
  - pop and START entry at E+1, so `uart_tx` = 0 and `busy` = 1 from E+1, and `fifo_count` returns to 0;
  - the start bit holds for exactly CLK_DIV cycles.
- **Bit hold**: every bit holds for exactly CLK_DIV cycles. There are no extra cycles between bits, nor between chained frames.
- **End of frame**: `busy` falls at the edge that ends the last stop bit, if the FIFO is empty. `uart_tx` stays 1.
- **`ready`** reflects the count after the current edge. It falls the cycle after the push that fills the FIFO.

## Test plan
- **8N1, CLK_DIV=4.** Push 0x55.
  - `uart_tx` sequence 0,1,0,1,0,1,0,1,0,1, each held 4 cycles.
  - `busy` high for exactly 40 cycles; line high afterwards.
- **8E1 / 8O1.** Push 0xA5 (four ones).
  - Even: parity bit 0, frame 44 cycles at CLK_DIV=4.
  - Odd: parity bit 1.
- **7O2, CLK_DIV=3.** Push 0x41.
  - Data bits 1,0,0,0,0,0,1; parity 1; two stop bits.
  - Total 11 bits = 33 cycles.
- **FIFO depth 4, 8N1, CLK_DIV=4.** Push 0x01,0x02,0x03,0x04,0x05 on consecutive cycles.
  - First four accepted; the first pops one cycle after its push.
  - 0x05 is accepted only if `ready` was high that cycle; check against `fifo_count`.
  - Frames are contiguous: the start bit of frame n+1 immediately follows the stop bit of frame n.
  - `busy` stays high throughout.
- **Full refusal.** Stall with the FIFO holding 4 words while the serialiser is mid-frame, then pulse `send` with 0xEE.
  - `ready` = 0, `fifo_count` stays 4, and 0xEE never appears on the line.
- **Reset mid-frame.** Drop `rst` for 1 cycle during data bit 3 with 2 words queued.
  - After that edge: `uart_tx` = 1, `busy` = 0, `fifo_count` = 0.
  - No further frames are sent.
